// File: rtl/npu_cmd_responder.sv
// Responder for custom-0 NPU instructions: accepts one command, launches the
// matmul/conv engine, waits for completion or timeout, then returns a response.
module npu_cmd_responder #(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_instr,
    input  logic [XLEN-1:0] cmd_rs1,
    input  logic [XLEN-1:0] cmd_rs2,
    output logic            npu_start,
    output logic [1:0]      npu_op,
    output logic [XLEN-1:0] npu_arg0,
    output logic [XLEN-1:0] npu_arg1,
    input  logic            npu_done,
    input  logic [XLEN-1:0] npu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_error,
    output logic [1:0]      rsp_err_code,
    output logic            busy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_MATMUL = 2'b01;
    localparam logic [1:0] OP_CONV   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   arg0_q, arg0_d;
    logic [XLEN-1:0]   arg1_q, arg1_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic              cmd_legal;
    logic [1:0]        cmd_mode;
    logic              unused_instr_bits;

    // Only opcode, funct3 and funct7 select the operation; rs1/rs2 fields arrive as values.
    assign unused_instr_bits = ^cmd_instr[24:15];
    assign cmd_legal = (cmd_instr[6:0] == 7'b0001011) && (cmd_instr[14:12] == 3'b000) &&
                       ((cmd_instr[31:25] == 7'b0000001) || (cmd_instr[31:25] == 7'b0000010));
    assign cmd_mode  = (cmd_instr[31:25] == 7'b0000001) ? OP_MATMUL : OP_CONV;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        arg0_d  = arg0_q;
        arg1_d  = arg1_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rd_d   = cmd_instr[11:7];
                    arg0_d = cmd_rs1;
                    arg1_d = cmd_rs2;
                    data_d = '0;
                    if (cmd_legal) begin
                        op_d    = cmd_mode;
                        err_d   = 1'b0;
                        code_d  = ERR_NONE;
                        state_d = START;
                    end else begin
                        op_d    = OP_NONE;
                        err_d   = 1'b1;
                        code_d  = ERR_ILLEGAL;
                        state_d = RESP;
                    end
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the final counted cycle still beats the timeout.
                if (npu_done) begin
                    data_d  = npu_result;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            rd_q    <= '0;
            arg0_q  <= '0;
            arg1_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            arg0_q  <= arg0_d;
            arg1_q  <= arg1_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign npu_start    = (state_q == START);
    assign npu_op       = ((state_q == START) || (state_q == WAIT)) ? op_q : OP_NONE;
    assign npu_arg0     = arg0_q;
    assign npu_arg1     = arg1_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_rd       = rd_q;
    assign rsp_data     = data_q;
    assign rsp_error    = err_q;
    assign rsp_err_code = code_q;

endmodule

// File: tb/tb_npu_cmd_responder.sv
// Self-checking bench for npu_cmd_responder: directed scenarios followed by
// randomized commands, all checked against a cycle-level response model.
module tb_npu_cmd_responder;

    localparam int XLEN = 64;
    localparam int TO   = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [31:0]     cmd_instr = '0;
    logic [XLEN-1:0] cmd_rs1 = '0;
    logic [XLEN-1:0] cmd_rs2 = '0;
    logic            npu_start;
    logic [1:0]      npu_op;
    logic [XLEN-1:0] npu_arg0;
    logic [XLEN-1:0] npu_arg1;
    logic            npu_done = 1'b0;
    logic [XLEN-1:0] npu_result = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [4:0]      rsp_rd;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_error;
    logic [1:0]      rsp_err_code;
    logic            busy;

    int n_compared = 0;
    int n_mismatched = 0;

    npu_cmd_responder #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_instr(cmd_instr),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .npu_start(npu_start), .npu_op(npu_op), .npu_arg0(npu_arg0), .npu_arg1(npu_arg1),
        .npu_done(npu_done), .npu_result(npu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .rsp_err_code(rsp_err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, ".npu_start"}, 64'(npu_start), 64'd0);
        checkOutput({tag, ".npu_op"}, 64'(npu_op), 64'd0);
    endtask

    function automatic logic [31:0] mkInstr(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [6:0] opc, input logic [4:0] rd);
        logic [4:0] rs1f;
        logic [4:0] rs2f;
        rs1f = 5'($urandom);
        rs2f = 5'($urandom);
        return {f7, rs2f, rs1f, f3, rd, opc};
    endfunction

    // Issues one command and follows it to the response handshake. done_k is the
    // cycle offset from accept at which the engine pulses done (0 = never).
    task automatic applyStimulus(input string tag, input logic [31:0] instr,
                                 input logic [63:0] rs1, input logic [63:0] rs2,
                                 input int done_k, input logic [63:0] result,
                                 input int stall, input bit spurious);
        bit         legal;
        logic [1:0] mode;
        int         rsp_k;
        logic       exp_err;
        logic [1:0] exp_code;
        logic [63:0] exp_data;

        legal = (instr[6:0] == 7'h0B) && (instr[14:12] == 3'd0) &&
                (instr[31:25] == 7'd1 || instr[31:25] == 7'd2);
        mode  = (instr[31:25] == 7'd1) ? 2'b01 : 2'b10;
        if (!legal) begin
            rsp_k = 1; exp_err = 1'b1; exp_code = 2'b01; exp_data = '0;
        end else if (done_k >= 2 && done_k <= TO + 1) begin
            rsp_k = done_k + 1; exp_err = 1'b0; exp_code = 2'b00; exp_data = result;
        end else begin
            rsp_k = TO + 2; exp_err = 1'b1; exp_code = 2'b10; exp_data = '0;
        end

        checkOutput({tag, ".ready_before"}, 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_instr = instr;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        step();
        cmd_valid = 1'b0;
        cmd_instr = 32'($urandom);
        cmd_rs1   = {$urandom, $urandom};
        cmd_rs2   = {$urandom, $urandom};

        for (int k = 1; k <= rsp_k + stall; k++) begin
            checkOutput({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd0);
            checkOutput({tag, ".busy"}, 64'(busy), 64'd1);
            checkOutput({tag, ".npu_start"}, 64'(npu_start), 64'(legal && k == 1));
            checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(k >= rsp_k));
            checkOutput({tag, ".npu_op"}, 64'(npu_op), (legal && k < rsp_k) ? 64'(mode) : 64'd0);
            if (legal && k < rsp_k) begin
                checkOutput({tag, ".npu_arg0"}, npu_arg0, rs1);
                checkOutput({tag, ".npu_arg1"}, npu_arg1, rs2);
            end
            if (k >= rsp_k) begin
                checkOutput({tag, ".rsp_rd"}, 64'(rsp_rd), 64'(instr[11:7]));
                checkOutput({tag, ".rsp_data"}, rsp_data, exp_data);
                checkOutput({tag, ".rsp_error"}, 64'(rsp_error), 64'(exp_err));
                checkOutput({tag, ".rsp_err_code"}, 64'(rsp_err_code), 64'(exp_code));
            end
            npu_done   = (k == done_k) || (spurious && k == 1);
            npu_result = (k == done_k) ? result : {$urandom, $urandom};
            rsp_ready  = (k >= rsp_k + stall);
            step();
        end
        npu_done  = 1'b0;
        rsp_ready = 1'b0;
        checkIdle({tag, ".after"});
    endtask

    initial begin
        logic [6:0] f7;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [31:0] ins;
        int cat;
        int dk;

        $display("[TB] start");
        // Reset check
        step();
        step();
        checkIdle("in_reset");
        rst_n = 1'b1;
        step();
        checkIdle("reset");
        checkOutput("reset.rsp_data", rsp_data, 64'd0);
        checkOutput("reset.rsp_error", 64'(rsp_error), 64'd0);
        checkOutput("reset.npu_arg0", npu_arg0, 64'd0);

        // Matmul, done at T+6
        applyStimulus("matmul", mkInstr(7'd1, 3'd0, 7'h0B, 5'd5), 64'h1000, 64'h2000,
                      6, 64'hDEAD, 0, 1'b0);
        // Conv with a 4-cycle response stall
        applyStimulus("conv", mkInstr(7'd2, 3'd0, 7'h0B, 5'd17), 64'hABCD_0001, 64'h55,
                      4, 64'h1234_5678_9ABC_DEF0, 4, 1'b0);
        // Illegal encodings
        applyStimulus("ill_opc", mkInstr(7'd1, 3'd0, 7'b0101011, 5'd3), 64'h1, 64'h2,
                      3, 64'h99, 0, 1'b0);
        applyStimulus("ill_f7", mkInstr(7'd3, 3'd0, 7'h0B, 5'd9), 64'h3, 64'h4,
                      3, 64'h99, 1, 1'b0);
        applyStimulus("ill_f3", mkInstr(7'd1, 3'd1, 7'h0B, 5'd0), 64'h5, 64'h6,
                      3, 64'h99, 0, 1'b0);
        // Timeout, then done on the last WAIT cycle
        applyStimulus("timeout", mkInstr(7'd1, 3'd0, 7'h0B, 5'd7), 64'h10, 64'h20,
                      0, 64'h0, 0, 1'b0);
        applyStimulus("done_last", mkInstr(7'd1, 3'd0, 7'h0B, 5'd8), 64'h11, 64'h21,
                      TO + 1, 64'hCAFE_F00D, 0, 1'b0);
        // Done during START is ignored; rd=0 still responds
        applyStimulus("spurious", mkInstr(7'd2, 3'd0, 7'h0B, 5'd0), 64'h12, 64'h22,
                      4, 64'h77, 2, 1'b1);

        // Reset mid-WAIT: assert 3 cycles after the start pulse
        checkOutput("rst_mid.ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_instr = mkInstr(7'd1, 3'd0, 7'h0B, 5'd4);
        cmd_rs1   = 64'hA;
        cmd_rs2   = 64'hB;
        step();
        cmd_valid = 1'b0;
        checkOutput("rst_mid.start", 64'(npu_start), 64'd1);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkIdle("rst_mid.async");
        step();
        step();
        rst_n = 1'b1;
        npu_done   = 1'b1;
        npu_result = 64'hBAD;
        step();
        npu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkIdle("rst_mid.ignore_done");
            step();
        end
        applyStimulus("after_rst", mkInstr(7'd2, 3'd0, 7'h0B, 5'd30), 64'hC, 64'hD,
                      5, 64'h4242, 1, 1'b0);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            cat = $urandom_range(0, 4);
            f7 = 7'd1; f3 = 3'd0; opc = 7'h0B;
            case (cat)
                0: f7 = 7'd1;
                1: f7 = 7'd2;
                2: begin
                    opc = 7'($urandom);
                    if (opc == 7'h0B) opc = 7'h0A;
                end
                3: begin
                    f7 = 7'($urandom);
                    if (f7 == 7'd1 || f7 == 7'd2) f7 = 7'h40;
                end
                default: f3 = 3'($urandom_range(1, 7));
            endcase
            ins = mkInstr(f7, f3, opc, 5'($urandom));
            dk = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TO + 3));
            applyStimulus("rand", ins, {$urandom, $urandom}, {$urandom, $urandom},
                          dk, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/npu_cmd_responder.md
Name: npu_cmd_responder

Overview:
- NPU-side responder for custom-0 instructions issued by the core.
- Accepts one instruction word plus rs1/rs2 operands over a valid/ready command channel and decodes funct7 into an NPU operation mode.
- Launches the NPU engine, waits for completion or timeout, then returns a response (rd, data, error) over a valid/ready response channel.
- Sits between the core execute stage and the matmul/conv engine; one command outstanding at a time.

Parameters:
- XLEN, 64: operand, argument and result width.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in WAIT before a timeout response; must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  core presents a command
- cmd_ready  out  1  responder accepts a command; high only in IDLE
- cmd_instr  in  32  raw instruction word
- cmd_rs1  in  XLEN  rs1 operand value
- cmd_rs2  in  XLEN  rs2 operand value
- npu_start  out  1  single-cycle engine launch pulse
- npu_op  out  2  NPU_OP_NONE=00, NPU_OP_MATMUL=01, NPU_OP_CONV=10
- npu_arg0  out  XLEN  latched rs1, stable from START through WAIT
- npu_arg1  out  XLEN  latched rs2, stable from START through WAIT
- npu_done  in  1  engine completion pulse
- npu_result  in  XLEN  engine result, valid with npu_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  core accepts response
- rsp_rd  out  5  destination register, cmd_instr[11:7] of the accepted command
- rsp_data  out  XLEN  result value
- rsp_error  out  1  command failed
- rsp_err_code  out  2  00 none, 01 illegal, 10 timeout, 11 reserved (never driven)
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE. All outputs 0 except cmd_ready=1; npu_op=00; internal latches and timeout counter cleared.
- Reset asserted mid-operation: immediate return to IDLE. No npu_start is emitted, any pending response is discarded, and a later npu_done is ignored.
- Accept: handshake when cmd_valid & cmd_ready in IDLE. Latch instr, rs1 and rs2 that cycle.
- Legal decode: opcode==7'b0001011, funct3==3'b000, and funct7 is 7'b0000001 (MATMUL) or 7'b0000010 (CONV). Anything else is illegal.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE -> START when an accepted command is legal; IDLE -> RESP when illegal (rsp_error=1, code=01, data=0).
- START: npu_start=1 for exactly one cycle; npu_op = decoded mode; npu_arg0/1 = latched operands. Always -> WAIT next cycle, with the timeout counter cleared.
- WAIT: npu_op held. On npu_done, latch npu_result into rsp_data with error=0 and code=00, then -> RESP.
- WAIT timeout: the counter increments each WAIT cycle without done. When counter==TIMEOUT_CYCLES-1 and no done, -> RESP with error=1, code=10, data=0. If npu_done arrives on that same final cycle, done wins.
- RESP: rsp_valid=1, and rsp_rd/data/error/err_code are held stable until rsp_ready. On the handshake cycle -> IDLE, with cmd_ready=1 from the next cycle. rsp_valid must not drop before the handshake.
- npu_op: returns to 00 on leaving WAIT. npu_arg0/1 hold their last values outside START/WAIT.
- npu_done outside WAIT (including during START) is ignored.
- rd==0 is not special-cased; a response is still produced.
- Latency, with accept at cycle T:
  - illegal: rsp_valid at T+1
  - legal: npu_start at T+1, WAIT from T+2; done at cycle D>=T+2 gives rsp_valid at D+1
  - timeout: rsp_valid at T+2+TIMEOUT_CYCLES
- No back-to-back accept: cmd_ready is low from T+1 until the cycle after the response handshake.

Test Plan (TIMEOUT_CYCLES=16 for bench):
- Reset check: hold rst_n low, then release with cmd_valid=0 -> cmd_ready=1, rsp_valid=0, npu_start=0, npu_op=00, busy=0.
- Matmul: instr funct7=0000001, opcode 0001011, rd=5, rs1=0x1000, rs2=0x2000, accepted at T; engine done at T+6 with result 0xDEAD ->
  - npu_start pulse at T+1 only, npu_op=01, arg0/arg1=0x1000/0x2000 through T+6
  - rsp_valid at T+7 with rd=5, data=0xDEAD, error=0
- Conv with rsp_ready held low for 4 cycles -> npu_op=10; response fields stable for all 4 stalled cycles; IDLE after the handshake; next cmd_ready one cycle later.
- Illegal: opcode 0101011, then opcode 0001011 with funct7=0000011, then funct3=001 -> each gives rsp_valid at T+1, error=1, code=01, data=0, and no npu_start.
- Timeout: legal matmul with npu_done never asserted -> rsp_valid at T+18, code=10. Second run with done on the last WAIT cycle -> error=0 and data equals the result.
- Reset mid-WAIT: assert rst_n low 3 cycles after start -> immediate return to IDLE. A later npu_done produces no response, and the next command runs normally.
